// File: rtl/t_cnt_pkg.sv
// rtl/t_cnt_pkg.sv - shared constants, direction type and wrap/clamp target helper for t_updown_counter
package t_cnt_pkg;

    localparam int T_CNT_WIDTH_DEF = 4;
    localparam int T_CNT_MOD_DEF   = 16;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Value the count lands on when it runs off the end in direction dir.
    // The down-direction target (MODULUS-1) doubles as the load clamp value.
    function automatic int t_cnt_target(input int modulus, input dir_e dir);
        return (dir == DIR_UP) ? 0 : modulus - 1;
    endfunction

endpackage

// File: rtl/t_cell.sv
// rtl/t_cell.sv - one T-type storage cell with synchronous reset and parallel load
// Ports: clk (rising edge), rst (sync, active-high), t (toggle), ld (load), d (load data), q (stored bit)
module t_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (ld) begin
            q <= d;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/t_updown_counter.sv
// rtl/t_updown_counter.sv - modulo-N up/down counter built from a bank of t_cell toggle cells
// Ports: clk, rst (sync, active-high), en, up, load, load_val -> q (registered count),
//        t_vec (combinational toggle vector), tc (combinational terminal count), wrap (registered pulse)
// Build option: define T_CNT_SAT_EN to saturate at the ends instead of wrapping.
module t_updown_counter
    import t_cnt_pkg::*;
#(
    parameter int WIDTH   = T_CNT_WIDTH_DEF,
    parameter int MODULUS = T_CNT_MOD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t_vec,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(t_cnt_target(MODULUS, DIR_DOWN));

    dir_e             dir;
    logic             at_end;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] t_next;
    logic             wrap_next;
    logic             carry;

    assign dir    = dir_e'(up);
    assign at_end = (dir == DIR_UP) ? (q == MAX_VAL) : (q == '0);
    assign tc     = ~rst & en & at_end;
    assign t_vec  = t_next;

    always_comb begin
        t_next    = '0;
        ld        = 1'b0;
        ld_val    = '0;
        wrap_next = 1'b0;
        carry     = 1'b1;
        if (!rst) begin
            if (load) begin
                ld     = 1'b1;
                ld_val = (load_val > MAX_VAL) ? MAX_VAL : load_val;
                t_next = q ^ ld_val;
            end else if (en) begin
                if (at_end) begin
`ifdef T_CNT_SAT_EN
                    t_next = '0;
`else
                    t_next    = q ^ WIDTH'(t_cnt_target(MODULUS, dir));
                    wrap_next = 1'b1;
`endif
                end else begin
                    // Bit i flips when every lower bit equals up: all ones
                    // for increment, all zeros for decrement.
                    for (int i = 0; i < WIDTH; i++) begin
                        t_next[i] = carry;
                        carry     = carry & (q[i] ~^ up);
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        t_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t_next[g]),
            .ld  (ld),
            .d   (ld_val[g]),
            .q   (q[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_t_updown_counter.sv
// tb/tb_t_updown_counter.sv - self-checking bench for t_updown_counter at MODULUS 16, 10 and 2
module tb_t_updown_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] q_o    [3];
    logic [3:0] tvec_o [3];
    logic       tc_o   [3];
    logic       wrap_o [3];

    int mods [3] = '{16, 10, 2};
    int mq   [3] = '{0, 0, 0};

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [2:0][3:0] q;
        logic [2:0]      w;
    } exp_t;

    exp_t sb [$];

    always #5 clk = ~clk;

    t_updown_counter #(.WIDTH(4), .MODULUS(16)) u_m16 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q_o[0]), .t_vec(tvec_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0])
    );
    t_updown_counter #(.WIDTH(4), .MODULUS(10)) u_m10 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q_o[1]), .t_vec(tvec_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1])
    );
    t_updown_counter #(.WIDTH(4), .MODULUS(2)) u_m2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q_o[2]), .t_vec(tvec_o[2]), .tc(tc_o[2]), .wrap(wrap_o[2])
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input logic r, input logic ld, input logic [3:0] lv, input logic e, input logic u);
        exp_t ex;
        exp_t got;
        int   nq;
        logic nw;
        rst = r; load = ld; load_val = lv; en = e; up = u;
        #3;
        for (int k = 0; k < 3; k++) begin
            nw = 1'b0;
            if (r) begin
                nq = 0;
            end else if (ld) begin
                nq = (int'(lv) > mods[k] - 1) ? mods[k] - 1 : int'(lv);
            end else if (e && u) begin
                if (mq[k] == mods[k] - 1) begin
`ifdef T_CNT_SAT_EN
                    nq = mq[k];
`else
                    nq = 0; nw = 1'b1;
`endif
                end else begin
                    nq = mq[k] + 1;
                end
            end else if (e) begin
                if (mq[k] == 0) begin
`ifdef T_CNT_SAT_EN
                    nq = 0;
`else
                    nq = mods[k] - 1; nw = 1'b1;
`endif
                end else begin
                    nq = mq[k] - 1;
                end
            end else begin
                nq = mq[k];
            end
            check($sformatf("t_vec[m%0d]", mods[k]), tvec_o[k], r ? 4'h0 : 4'(nq ^ mq[k]));
            check($sformatf("tc[m%0d]", mods[k]), {3'b0, tc_o[k]},
                  {3'b0, ~r & e & (u ? (mq[k] == mods[k] - 1) : (mq[k] == 0))});
            ex.q[k] = 4'(nq);
            ex.w[k] = nw;
            mq[k]   = nq;
        end
        sb.push_back(ex);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("q[m%0d]", mods[k]), q_o[k], got.q[k]);
            check($sformatf("wrap[m%0d]", mods[k]), {3'b0, wrap_o[k]}, {3'b0, got.w[k]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset asserted together with load and en: reset wins.
        step(1, 1, 4'd5, 1, 1);
        step(1, 1, 4'd5, 1, 1);
        check("reset_q", q_o[0], 4'd0);

        // Count to 7, then reset mid-count with load and en also high.
        repeat (7) step(0, 0, 4'd0, 1, 1);
        check("count7", q_o[0], 4'd7);
        step(1, 1, 4'd9, 1, 1);
        check("rst_mid", q_o[0], 4'd0);
        step(1, 0, 4'd0, 1, 1);
        check("rst_hold", q_o[0], 4'd0);

        // Full-range up run; MODULUS=2 instance wraps every edge.
        repeat (16) step(0, 0, 4'd0, 1, 1);
`ifdef T_CNT_SAT_EN
        check("up16_q", q_o[0], 4'd15);
`else
        check("up16_q", q_o[0], 4'd0);
        check("up16_wrap", {3'b0, wrap_o[0]}, 4'd1);
`endif
        step(0, 0, 4'd0, 1, 1);

        // Load 0 then count down through the non-power-of-2 wrap.
        step(0, 1, 4'd0, 0, 0);
        repeat (3) step(0, 0, 4'd0, 1, 0);
`ifdef T_CNT_SAT_EN
        check("down10", q_o[1], 4'd0);
`else
        check("down10", q_o[1], 4'd7);
`endif

        // Load clamp and load-over-enable priority.
        step(0, 1, 4'd13, 1, 1);
        check("clamp10", q_o[1], 4'd9);
        step(0, 1, 4'd3, 1, 1);
        check("load3", q_o[1], 4'd3);

        // Direction flip then hold.
        step(0, 1, 4'd5, 0, 1);
        step(0, 0, 4'd0, 1, 1);
        step(0, 0, 4'd0, 1, 0);
        repeat (3) step(0, 0, 4'd0, 0, 0);
        check("hold5", q_o[0], 4'd5);

        // Pushing past the top and the bottom.
        step(0, 1, 4'd15, 0, 1);
        repeat (4) step(0, 0, 4'd0, 1, 1);
        step(0, 1, 4'd0, 0, 0);
        repeat (2) step(0, 0, 4'd0, 1, 0);

        // Mixed random traffic.
        repeat (80) begin
            step(($urandom % 16) == 0, ($urandom % 8) == 0, 4'($urandom),
                 ($urandom % 4) != 0, 1'($urandom));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/t_updown_counter.md
Name: t_updown_counter

Overview:
- Synchronous modulo-N up/down counter built as a bank of T-type storage cells.
- Control logic computes the per-bit toggle vector T each cycle; each cell flips its bit when its T bit is 1.
- Sits directly upstream of the T-flip-flop stage: it generates the T inputs and owns the count state.
- Provides the counter, divider and terminal-count primitive for the sequential-logic series.

Parameters:
- WIDTH, 4, counter width in bits (2..16).
- MODULUS, 16, count sequence 0..MODULUS-1; legal range 2..2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  current count, registered.
- t_vec  output  WIDTH  toggle vector applied this cycle, combinational (q_next ^ q).
- tc  output  1  terminal count, combinational:
  - up=1: en & (q==MODULUS-1).
  - up=0: en & (q==0).
- wrap  output  1  registered one-cycle pulse, asserted the cycle after a wrap occurred.

Behaviour:
- Reset: rst=1 at a clk edge gives q=0 and wrap=0. rst has priority over load and en. t_vec=0 and tc=0 while rst=1.
- Priority per edge: rst > load > en > hold.
- Load:
  - q <= load_val when load_val <= MODULUS-1.
  - Otherwise q <= MODULUS-1 (clamp).
  - wrap <= 0. t_vec = q ^ loaded value.
- Count, en=1 and load=0:
  - Up with q < MODULUS-1: q <= q+1.
  - Up with q == MODULUS-1: q <= 0 and wrap <= 1.
  - Down with q > 0: q <= q-1.
  - Down with q == 0: q <= MODULUS-1 and wrap <= 1.
- Toggle generation:
  - Non-wrap increment: T[i] = AND of q[j] for j<i. T[0]=1.
  - Non-wrap decrement: T[i] = AND of ~q[j] for j<i.
  - Wrap: T = q ^ wrap target.
  - The hardware forms T only; the cells do the flipping. No adder on the q path.
- Hold (en=0, load=0): T=0, q unchanged, wrap <= 0.
- wrap is exactly one cycle wide. On back-to-back wraps (MODULUS=2 with en held) it stays high continuously.
- Direction change: up may change on any cycle. The next edge uses the new direction with no dead cycle.
- Latency: q reflects en/load/up one edge after sampling.
- No X ever appears on q; there is no illegal state.

Optional Feature:
- Macro: T_CNT_SAT_EN.
- Defined: saturating mode.
  - Up at MODULUS-1 or down at 0 gives T=0; q holds.
  - wrap is never asserted.
  - tc keeps the same definition (acts as the saturated flag).
- Undefined: modulo wrap behaviour as above.

Decomposition:
- Package t_cnt_pkg:
  - default constants T_CNT_WIDTH_DEF=4 and T_CNT_MOD_DEF=16.
  - typedef enum for direction: DIR_DOWN=0, DIR_UP=1.
  - a function computing the clamp/wrap target for a given MODULUS.
- Sub-module t_cell: one bit of storage.
  - Ports clk, rst, t, ld, d, q.
  - Behaviour: sync reset to 0; ld gives q<=d; otherwise t gives q<=~q.
  - Instantiated WIDTH times via generate.
  - All toggle computation stays in t_updown_counter.

Test Plan:
- Reset mid-count: WIDTH=4, MODULUS=16, count to q=7, then rst=1 with en=1 and load=1 -> next edge q=0, wrap=0; q holds 0 while rst=1.
- Full-range up wrap: MODULUS=16, en=1, up=1 for 17 edges from 0 -> q reaches 15 with tc=1, then q=0 with wrap=1 for exactly one cycle; t_vec=4'b1111 at 15->0.
- Non-power-of-2 down: MODULUS=10, load 0, then en=1, up=0 -> q=9 and wrap pulses; next edges q=8, 7; t_vec at 8->7 = 4'b1111.
- Load clamp and priority: MODULUS=10, load=1, load_val=13, en=1 -> q=9, wrap=0; then load_val=3 -> q=3.
- Direction flip: q=5, up=1 then up=0 on consecutive edges -> q=6 then 5; en=0 for 3 cycles -> q holds 5 and t_vec=0.
- T_CNT_SAT_EN build: MODULUS=16, q=15, up=1, en=1 for 4 edges -> q stays 15, tc=1, wrap=0; down from 0 -> q stays 0.
